// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO in the clk domain, decodes
// management frames and serves them from an external 32 x 16-bit register file.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'h03,
    parameter int         PREAMBLE_MIN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_rx_data,
    output logic        mdio_tx_data,
    output logic        mdio_tx_en,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr,
    output logic [15:0] reg_wr_data,
    output logic        busy,
    output logic        frame_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
    localparam logic [5:0] PRE_SAT = 6'd32;

    // Bit 1 carries MDC, bit 0 carries MDIO; both see the same depth so a
    // detected edge and its sampled data bit stay aligned.
    logic [1:0]  pin_meta_reg, pin_sync_reg;
    logic        mdc_prev_reg, edge_reg, bit_reg;

    state_t      state_reg, state_next;
    logic [4:0]  edge_cnt_reg, edge_cnt_next;
    logic [5:0]  pre_cnt_reg, pre_cnt_next;
    logic [3:0]  shift_reg, shift_next;
    logic        is_read_reg, is_read_next;
    logic [4:0]  reg_addr_reg, reg_addr_next;
    logic [15:0] wr_data_reg, wr_data_next;
    logic [15:0] tx_shift_reg, tx_shift_next;
    logic        tx_en_reg, tx_en_next;
    logic        tx_data_reg, tx_data_next;
    logic        rd_reg, rd_next;
    logic        wr_reg, wr_next;
    logic        err_reg, err_next;
    logic        busy_reg, busy_next;
    logic        capture_reg, capture_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_meta_reg <= 2'b00;
            pin_sync_reg <= 2'b00;
            mdc_prev_reg <= 1'b0;
            edge_reg     <= 1'b0;
            bit_reg      <= 1'b0;
        end else begin
            pin_meta_reg <= {mdc, mdio_rx_data};
            pin_sync_reg <= pin_meta_reg;
            mdc_prev_reg <= pin_sync_reg[1];
            edge_reg     <= pin_sync_reg[1] & ~mdc_prev_reg;
            bit_reg      <= pin_sync_reg[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            edge_cnt_reg <= 5'd0;
            pre_cnt_reg  <= 6'd0;
            shift_reg    <= 4'd0;
            is_read_reg  <= 1'b0;
            reg_addr_reg <= 5'd0;
            wr_data_reg  <= 16'd0;
            tx_shift_reg <= 16'd0;
            tx_en_reg    <= 1'b0;
            tx_data_reg  <= 1'b0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            capture_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            pre_cnt_reg  <= pre_cnt_next;
            shift_reg    <= shift_next;
            is_read_reg  <= is_read_next;
            reg_addr_reg <= reg_addr_next;
            wr_data_reg  <= wr_data_next;
            tx_shift_reg <= tx_shift_next;
            tx_en_reg    <= tx_en_next;
            tx_data_reg  <= tx_data_next;
            rd_reg       <= rd_next;
            wr_reg       <= wr_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
            capture_reg  <= capture_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        pre_cnt_next  = pre_cnt_reg;
        shift_next    = shift_reg;
        is_read_next  = is_read_reg;
        reg_addr_next = reg_addr_reg;
        wr_data_next  = wr_data_reg;
        // Read data arrives the cycle after reg_rd; capture it one cycle later.
        tx_shift_next = capture_reg ? reg_rd_data : tx_shift_reg;
        tx_en_next    = tx_en_reg;
        tx_data_next  = tx_data_reg;
        rd_next       = 1'b0;
        wr_next       = 1'b0;
        err_next      = 1'b0;
        busy_next     = busy_reg;
        capture_next  = rd_reg;

        if (edge_reg) begin
            edge_cnt_next = edge_cnt_reg + 5'd1;
            case (state_reg)
                S_IDLE: begin
                    edge_cnt_next = 5'd1;
                    if (bit_reg) begin
                        if (pre_cnt_reg != PRE_SAT) pre_cnt_next = pre_cnt_reg + 6'd1;
                    end else begin
                        pre_cnt_next = 6'd0;
                        if (pre_cnt_reg >= PRE_MIN) begin
                            state_next = S_START;
                            busy_next  = 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (bit_reg) begin
                        state_next = S_OP;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                        busy_next  = 1'b0;
                    end
                end
                S_OP: begin
                    shift_next = {shift_reg[2:0], bit_reg};
                    if (edge_cnt_reg == 5'd3) begin
                        if ({shift_reg[0], bit_reg} == 2'b10 || {shift_reg[0], bit_reg} == 2'b01) begin
                            is_read_next = shift_reg[0];
                            state_next   = S_PHYAD;
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_IDLE;
                            busy_next  = 1'b0;
                        end
                    end
                end
                S_PHYAD: begin
                    shift_next = {shift_reg[2:0], bit_reg};
                    if (edge_cnt_reg == 5'd8)
                        state_next = ({shift_reg, bit_reg} == PHY_ADDR) ? S_REGAD : S_SKIP;
                end
                S_REGAD: begin
                    reg_addr_next = {reg_addr_reg[3:0], bit_reg};
                    if (edge_cnt_reg == 5'd13) begin
                        state_next = S_TA;
                        rd_next    = is_read_reg;
                    end
                end
                S_TA: begin
                    if (is_read_reg) begin
                        if (edge_cnt_reg == 5'd14) begin
                            tx_en_next   = 1'b1;
                            tx_data_next = 1'b0;
                        end else begin
                            tx_data_next  = tx_shift_reg[15];
                            tx_shift_next = {tx_shift_reg[14:0], 1'b0};
                        end
                    end
                    if (edge_cnt_reg == 5'd15) state_next = S_DATA;
                end
                S_DATA: begin
                    if (is_read_reg) begin
                        if (edge_cnt_reg == 5'd31) begin
                            tx_en_next   = 1'b0;
                            tx_data_next = 1'b0;
                        end else begin
                            tx_data_next  = tx_shift_reg[15];
                            tx_shift_next = {tx_shift_reg[14:0], 1'b0};
                        end
                    end else begin
                        wr_data_next = {wr_data_reg[14:0], bit_reg};
                        wr_next      = (edge_cnt_reg == 5'd31);
                    end
                    if (edge_cnt_reg == 5'd31) begin
                        state_next = S_IDLE;
                        busy_next  = 1'b0;
                    end
                end
                S_SKIP: begin
                    if (edge_cnt_reg == 5'd31) begin
                        state_next = S_IDLE;
                        busy_next  = 1'b0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    assign mdio_tx_data = tx_data_reg;
    assign mdio_tx_en   = tx_en_reg;
    assign reg_addr     = reg_addr_reg;
    assign reg_rd       = rd_reg;
    assign reg_wr       = wr_reg;
    assign reg_wr_data  = wr_data_reg;
    assign busy         = busy_reg;
    assign frame_err    = err_reg;
endmodule
